// File: rtl/xmaxpool.sv
// Streaming 2x2 stride-2 signed max-pooling stage with a half-width line buffer of pair maxima.
// Optional `XMAXPOOL_BYPASS_EN` adds a `bypass` input that registers every pixel straight through.
module xmaxpool #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINE_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [LINE_W-1:0] width,
    input  logic [LINE_W-1:0] height,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
`ifdef XMAXPOOL_BYPASS_EN
    input  logic              bypass,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              done
);

    localparam int unsigned DEPTH = 2 ** (LINE_W - 1);

    logic [LINE_W-1:0]        col_q, col_d;
    logic [LINE_W-1:0]        row_q, row_d;
    logic signed [DATA_W-1:0] hold_q, hold_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     done_q, done_d;

    logic signed [DATA_W-1:0] linebuf [DEPTH];
    logic [LINE_W-2:0]        lb_addr;
    logic                     lb_we;
    logic signed [DATA_W-1:0] lb_rd;
    logic signed [DATA_W-1:0] din;
    logic signed [DATA_W-1:0] pm;
    logic signed [DATA_W-1:0] pool;
    logic                     last_col;
    logic                     last_row;
    logic                     pool_en;

    assign din      = $signed(in_data);
    assign lb_addr  = col_q[LINE_W-1:1];
    assign lb_rd    = linebuf[lb_addr];
    assign last_col = (col_q == width - LINE_W'(1));
    assign last_row = (row_q == height - LINE_W'(1));

`ifdef XMAXPOOL_BYPASS_EN
    assign pool_en = ~bypass;
`else
    assign pool_en = 1'b1;
`endif

    always_comb begin
        pm   = (hold_q > din) ? hold_q : din;
        pool = (lb_rd > pm) ? lb_rd : pm;
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        lb_we       = 1'b0;

        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (in_valid) begin
            if (!col_q[0]) begin
                hold_d = din;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else if (pool_en) begin
                out_valid_d = 1'b1;
                out_data_d  = pool;
                done_d      = last_col && last_row;
            end

            // Bypass forwards every pixel; counters keep running so `done` still marks the frame end.
            if (!pool_en) begin
                out_valid_d = 1'b1;
                out_data_d  = din;
                done_d      = last_col && last_row;
            end

            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + LINE_W'(1);
            end else begin
                col_d = col_q + LINE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // No reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_addr] <= pm;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule
